// File: rtl/key_filter_4.sv
// -----------------------------------------------------------------------------
// key_filter_4
//
// Four-key front end for the board's raw push-buttons. Each active-low key is
// brought into the sys_clk domain through a two-flop synchroniser, then
// debounced by its own four-state filter with a 25-bit stability counter. The
// block reports a clean pressed level, one-cycle press/release pulses, and a
// registered key index with a valid strobe for the mode/control logic.
//
// Parameters:
//   CNT_MAX    - a key must be stable for CNT_MAX+1 cycles to change state
//   REPEAT_MAX - auto-repeat period minus one (only with KEY_REPEAT_EN)
//
// Ports:
//   sys_clk     in   1  system clock, rising edge
//   sys_rst     in   1  synchronous active-high reset
//   key_in      in   4  raw key pins, active-low, asynchronous to sys_clk
//   key_level   out  4  debounced state, 1 = pressed
//   key_press   out  4  one-cycle pulse per key on debounced press
//   key_release out  4  one-cycle pulse per key on debounced release
//   key_code    out  2  lowest-numbered key that pulsed key_press last cycle
//   key_valid   out  1  one-cycle strobe qualifying key_code
//
// Build option:
//   KEY_REPEAT_EN - when defined, a held key re-pulses key_press every
//                   REPEAT_MAX+1 cycles. When undefined the repeat counters
//                   are not built at all.
// -----------------------------------------------------------------------------
module key_filter_4 #(
  parameter logic [24:0] CNT_MAX    = 25'd999_999,
  parameter logic [24:0] REPEAT_MAX = 25'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [1:0] key_code,
  output logic       key_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; plain flop chain, nothing combinational in front of
  // the second stage. Reset value is "released".
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce filters
  // ---------------------------------------------------------------------------
  logic [3:0] press_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      state_t      state_q,   state_d;
      logic [24:0] cnt_q,     cnt_d;
      logic        level_q,   level_d;
      logic        press_q,   press_d;
      logic        release_q, release_d;
      logic        key_s;

      assign key_s = sync2_q[gi];

`ifdef KEY_REPEAT_EN
      logic [24:0] rpt_q, rpt_d;
      logic        held_now;
      logic        held_next;

      assign held_now  = (state_q == DOWN) || (state_q == FILT_UP);
      assign held_next = (state_d == DOWN) || (state_d == FILT_UP);
`endif

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
          IDLE: begin
            if (!key_s) begin
              state_d = FILT_DN;
              cnt_d   = 25'd0;
            end
          end

          FILT_DN: begin
            if (key_s) begin
              // bounce: fall back without reporting anything
              state_d = IDLE;
              cnt_d   = 25'd0;
            end else if (cnt_q == CNT_MAX) begin
              state_d = DOWN;
              cnt_d   = 25'd0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 25'd1;
            end
          end

          DOWN: begin
            if (key_s) begin
              state_d = FILT_UP;
              cnt_d   = 25'd0;
            end
          end

          FILT_UP: begin
            if (!key_s) begin
              state_d = DOWN;
              cnt_d   = 25'd0;
            end else if (cnt_q == CNT_MAX) begin
              state_d   = IDLE;
              cnt_d     = 25'd0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 25'd1;
            end
          end

          default: begin
            state_d = IDLE;
            cnt_d   = 25'd0;
          end
        endcase

`ifdef KEY_REPEAT_EN
        // Repeat timer: restarts on every entry to DOWN, runs while the key is
        // held (DOWN/FILT_UP). A repeat is only issued when the key stays held
        // on this edge, so it can never coincide with the release pulse.
        rpt_d = rpt_q;
        if ((state_d == DOWN) && (state_q != DOWN)) begin
          rpt_d = 25'd0;
        end else if (held_now && held_next) begin
          if (rpt_q == REPEAT_MAX) begin
            rpt_d   = 25'd0;
            press_d = 1'b1;
          end else begin
            rpt_d = rpt_q + 25'd1;
          end
        end else begin
          rpt_d = 25'd0;
        end
`endif
      end

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          state_q   <= IDLE;
          cnt_q     <= 25'd0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

`ifdef KEY_REPEAT_EN
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          rpt_q <= 25'd0;
        end else begin
          rpt_q <= rpt_d;
        end
      end
`endif

      assign key_level[gi]   = level_q;
      assign press_vec[gi]   = press_q;
      assign key_release[gi] = release_q;
    end
  endgenerate

  assign key_press = press_vec;

  // ---------------------------------------------------------------------------
  // Encoder: one cycle behind key_press, lowest index wins, code holds when
  // nothing is pressed.
  // ---------------------------------------------------------------------------
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;

  always_comb begin
    valid_d = |press_vec;
    code_d  = code_q;
    if (press_vec[0]) begin
      code_d = 2'd0;
    end else if (press_vec[1]) begin
      code_d = 2'd1;
    end else if (press_vec[2]) begin
      code_d = 2'd2;
    end else if (press_vec[3]) begin
      code_d = 2'd3;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      code_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_key_filter_4.sv
// -----------------------------------------------------------------------------
// tb_key_filter_4
//
// Directed bench for key_filter_4 with CNT_MAX=4 and REPEAT_MAX=9. Inputs are
// driven 1 time unit after a rising edge; outputs are checked 1 time unit
// after each following edge. "Edge i" below counts rising edges after the new
// key_in value was applied, so a clean press appears at edge 8 and the
// encoder strobe at edge 9.
// -----------------------------------------------------------------------------
module tb_key_filter_4;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [1:0] key_code;
  logic       key_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_filter_4 #(
    .CNT_MAX    (25'd4),
    .REPEAT_MAX (25'd9)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_code    (key_code),
    .key_valid   (key_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ep, input logic [3:0] er,
                           input logic [3:0] el, input logic ev, input logic [1:0] ec);
    check({tag, ".press"},   {4'd0, key_press},   {4'd0, ep});
    check({tag, ".release"}, {4'd0, key_release}, {4'd0, er});
    check({tag, ".level"},   {4'd0, key_level},   {4'd0, el});
    check({tag, ".valid"},   {7'd0, key_valid},   {7'd0, ev});
    check({tag, ".code"},    {6'd0, key_code},    {6'd0, ec});
  endtask

  // n idle cycles with no pulses expected
  task automatic quiet(input string tag, input logic [3:0] lvl, input logic [1:0] code, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      check_all($sformatf("%s[%0d]", tag, i), 4'b0000, 4'b0000, lvl, 1'b0, code);
    end
  endtask

  // Apply kin and hold it for n edges. keys is the set of keys expected to
  // change; is_press selects press vs release behaviour.
  task automatic phase(input string tag, input logic [3:0] kin, input logic [3:0] keys,
                       input bit is_press, input logic [3:0] lvl_before,
                       input logic [3:0] lvl_after, input logic [1:0] code_before,
                       input logic [1:0] code_after, input int n);
    logic [3:0] ep, er, el;
    logic       ev;
    logic [1:0] ec;
    bit         pulse_now;
    bit         pulse_prev;
    pulse_prev = 1'b0;
    key_in = kin;
    for (int i = 1; i <= n; i++) begin
      tick();
      pulse_now = (i == 8) || (is_press && REP && (i > 8) && (((i - 8) % 10) == 0));
      ep = (is_press && pulse_now) ? keys : 4'b0000;
      er = (!is_press && pulse_now) ? keys : 4'b0000;
      el = (i >= 8) ? lvl_after : lvl_before;
      ev = is_press && pulse_prev;
      ec = (is_press && i >= 9) ? code_after : code_before;
      check_all($sformatf("%s[%0d]", tag, i), ep, er, el, ev, ec);
      pulse_prev = pulse_now;
    end
  endtask

  initial begin
    // ---- reset ----
    sys_rst = 1'b1;
    key_in  = 4'b1111;
    tick();
    tick();
    tick();
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    sys_rst = 1'b0;

    // ---- reset abandons a filter in progress ----
    key_in = 4'b1110;
    quiet("pre_rst", 4'b0000, 2'd0, 3);
    sys_rst = 1'b1;
    key_in  = 4'b1111;
    tick();
    check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    sys_rst = 1'b0;
    quiet("post_rst", 4'b0000, 2'd0, 20);

    // ---- key 0 clean press held 40 cycles, then release ----
    phase("k0_dn", 4'b1110, 4'b0001, 1'b1, 4'b0000, 4'b0001, 2'd0, 2'd0, 40);
    phase("k0_up", 4'b1111, 4'b0001, 1'b0, 4'b0001, 4'b0000, 2'd0, 2'd0, 20);

    // ---- key 2 short glitch: rejected ----
    key_in = 4'b1011;
    quiet("k2_glitch", 4'b0000, 2'd0, 3);
    key_in = 4'b1111;
    quiet("k2_after", 4'b0000, 2'd0, 15);

    // ---- key 1 bouncing then held ----
    for (int k = 0; k < 6; k++) begin
      key_in = ((k % 2) == 0) ? 4'b1101 : 4'b1111;
      tick();
      check_all($sformatf("k1_bounce[%0d]", k), 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    phase("k1_dn", 4'b1101, 4'b0010, 1'b1, 4'b0000, 4'b0010, 2'd0, 2'd1, 20);
    phase("k1_up", 4'b1111, 4'b0010, 1'b0, 4'b0010, 4'b0000, 2'd1, 2'd1, 20);

    // ---- keys 1 and 3 together: lowest index reported ----
    phase("k13_dn", 4'b0101, 4'b1010, 1'b1, 4'b0000, 4'b1010, 2'd1, 2'd1, 20);
    phase("k13_up", 4'b1111, 4'b1010, 1'b0, 4'b1010, 4'b0000, 2'd1, 2'd1, 20);

    // ---- keys 2 and 3 together: code moves to 2 ----
    phase("k23_dn", 4'b0011, 4'b1100, 1'b1, 4'b0000, 4'b1100, 2'd1, 2'd2, 20);
    phase("k23_up", 4'b1111, 4'b1100, 1'b0, 4'b1100, 4'b0000, 2'd2, 2'd2, 20);

    // ---- code holds while idle ----
    quiet("idle_hold", 4'b0000, 2'd2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_filter_4.md
Name: key_filter_4

Overview:
- Input-side counterpart of the LED running-light driver: reads four raw, bouncing, active-low push-buttons on the board.
- Synchronises each key to sys_clk, debounces each independently, and reports:
  - a clean pressed level per key,
  - one-cycle press and release pulses per key,
  - an encoded key index with a valid strobe, for the mode/control logic that steers the LED pattern.

Parameters:
- CNT_MAX, 25'd999_999: debounce window. A key must be stable for CNT_MAX+1 cycles (20 ms at 50 MHz). Legal range 1 to 2^25-1.
- REPEAT_MAX, 25'd24_999_999: auto-repeat period minus 1 (0.5 s at 50 MHz). Used only when KEY_REPEAT_EN is defined.

Ports:
- sys_clk      input   1  system clock; all logic on its rising edge
- sys_rst      input   1  reset, synchronous, active-high
- key_in       input   4  raw key pins, active-low (0 = pressed), asynchronous to sys_clk
- key_level    output  4  debounced state, 1 = pressed
- key_press    output  4  one-cycle pulse per key on debounced press
- key_release  output  4  one-cycle pulse per key on debounced release
- key_code     output  2  index of lowest-numbered key pulsing key_press in the previous cycle
- key_valid    output  1  one-cycle strobe qualifying key_code

Behaviour:
- Reset (synchronous, sys_rst=1 at a rising edge):
  - key_level, key_press, key_release, key_code, key_valid <= 0.
  - Synchroniser flops <= 4'b1111 (released).
  - All key FSMs <= IDLE; all counters <= 0.
  - Reset asserted mid-filter or mid-hold abandons the operation. No release pulse is generated for a key held across reset.
- Synchroniser: two flops per key. key_s = key_in delayed 2 cycles. No logic before the second flop.
- Per-key FSM, four identical instances, each with its own 25-bit counter:
  - IDLE: key_s=0 -> FILT_DN, cnt<=0. Otherwise stay.
  - FILT_DN:
    - key_s=1 -> IDLE, cnt<=0 (bounce rejected).
    - Else if cnt==CNT_MAX -> DOWN, key_level<=1, key_press<=1 for one cycle.
    - Else cnt<=cnt+1.
  - DOWN: key_s=1 -> FILT_UP, cnt<=0. Otherwise stay.
  - FILT_UP:
    - key_s=0 -> DOWN, cnt<=0.
    - Else if cnt==CNT_MAX -> IDLE, key_level<=0, key_release<=1 for one cycle.
    - Else cnt<=cnt+1.
- Latency: key_in falling and then stable produces a key_press pulse registered on the (CNT_MAX+4)-th rising edge after the first edge that samples key_in=0. Release has identical latency.
- Pulses:
  - key_press and key_release are registered outputs, high exactly one cycle per event.
  - They are never both high for the same key.
- Encoder (registered, one cycle after key_press):
  - key_valid <= |key_press.
  - key_code <= index of the lowest set bit of key_press.
  - When key_press==0, key_code holds its value.
- Simultaneous presses: each key pulses its own key_press bit; key_code reports the lowest index only.
- Counter saturation: none needed. The counter is cleared on every state entry and never exceeds CNT_MAX.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - Each key has a 25-bit repeat counter, cleared on entry to DOWN, running while in DOWN or FILT_UP.
  - When it reaches REPEAT_MAX, it clears and key_press pulses again for one cycle; key_valid/key_code follow.
  - Repeats continue until the key leaves DOWN/FILT_UP.
  - key_release and key_level are unaffected.
- Undefined:
  - Exactly one key_press pulse per debounced press.
  - Repeat counters and REPEAT_MAX logic are absent from the netlist.

Test Plan (CNT_MAX=4, REPEAT_MAX=9):
- Reset, then key_in=4'b1110 for 3 cycles, then assert sys_rst for 1 cycle -> all outputs 0; after reset, with key_in=1111 for 20 cycles, no pulses appear.
- key_in[0]=0 held 20 cycles -> key_press=4'b0001 for exactly one cycle on the 8th edge; key_level[0]=1 from then on; next cycle key_valid=1, key_code=0.
- key_in[2]=0 for 3 cycles then 1 -> key_press, key_level and key_valid remain 0 throughout.
- key_in[1] toggles every cycle for 6 cycles, then is held 0 -> single key_press[1] pulse 8 edges after the final falling sample; then held 1 -> single key_release[1] pulse 8 edges later, key_level[1]=0.
- key_in[1] and key_in[3] fall on the same cycle -> key_press=4'b1010 for one cycle; next cycle key_valid=1, key_code=1.
- KEY_REPEAT_EN defined, key_in[0] held 0 for 40 cycles -> key_press[0] pulses at the 8th edge, then every 10 cycles while held; without the macro, one pulse only.
